relu_maxpool_2x2: RTL and testbench

//  Stream stage directly downstream of conv_12x12: consumes its raster-order 32-bit conv results,

---
 rtl/cnn_pkg.sv | 15 +
 rtl/relu_maxpool_2x2_if.sv | 11 +
 rtl/pool_line_buf.sv | 21 ++
 rtl/relu_maxpool_2x2.sv | 89 ++++++++
 tb/tb_relu_maxpool_2x2.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN stream-stage constants and the signed max / ReLU helpers
package cnn_pkg;
    localparam int CONV_DATA_W = 32;
    localparam int POOL_IN_W   = 8;
    localparam int POOL_IN_H   = 8;

    function automatic logic [CONV_DATA_W-1:0] smax(input logic [CONV_DATA_W-1:0] a,
                                                    input logic [CONV_DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [CONV_DATA_W-1:0] relu(input logic [CONV_DATA_W-1:0] x);
        return x[CONV_DATA_W-1] ? '0 : x;
    endfunction
endpackage

// File: rtl/relu_maxpool_2x2_if.sv
// relu_maxpool_2x2_if: conv-sample input stream and pooled output stream of the pool stage
interface relu_maxpool_2x2_if #(parameter int DATA_W = cnn_pkg::CONV_DATA_W);
    logic [DATA_W-1:0] in_data;
    logic              in_invalid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              finish;

    modport master (output in_data, in_invalid, input out_data, out_valid, finish);
    modport slave  (input in_data, in_invalid, output out_data, out_valid, finish);
endinterface

// File: rtl/pool_line_buf.sv
// pool_line_buf: one row of horizontal pair maxima, sync write / combinational read
module pool_line_buf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are never read before being written within a frame, so no reset.
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: 2x2/stride-2 max pooling followed by ReLU on a raster-order conv stream
module relu_maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int IN_W   = POOL_IN_W,
    parameter int IN_H   = POOL_IN_H
) (
    input logic               clk,
    input logic               reset,
    relu_maxpool_2x2_if.slave pool
);
    localparam int PW = IN_W / 2;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int AW = (PW > 1) ? $clog2(PW) : 1;
    localparam int ON = PW * (IN_H / 2);
    localparam int OW = (ON > 1) ? $clog2(ON) : 1;

    if ((IN_W % 2) != 0 || (IN_H % 2) != 0) begin : g_geom_chk
        $error("relu_maxpool_2x2: IN_W and IN_H must be even");
    end
    if (DATA_W != CONV_DATA_W) begin : g_width_chk
        $error("relu_maxpool_2x2: DATA_W must equal cnn_pkg::CONV_DATA_W");
    end

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [OW-1:0]     ocnt_q, ocnt_d;
    logic [DATA_W-1:0] h_q, h_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              finish_q, finish_d;
    logic [DATA_W-1:0] lb_rdata, pair_max, win_max;
    logic [AW-1:0]     lb_addr;
    logic              accept, last_col, last_row, last_out, lb_we, fire;

    pool_line_buf #(.DEPTH(PW), .DATA_W(DATA_W), .AW(AW)) u_lbuf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (pair_max),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    // Even rows park the pair max in the line buffer; odd rows close the window.
    always_comb begin
        accept      = !pool.in_invalid;
        last_col    = col_q == CW'(IN_W - 1);
        last_row    = row_q == RW'(IN_H - 1);
        last_out    = ocnt_q == OW'(ON - 1);
        lb_addr     = AW'(col_q >> 1);
        pair_max    = smax(h_q, pool.in_data);
        win_max     = smax(lb_rdata, pair_max);
        lb_we       = accept && col_q[0] && !row_q[0];
        fire        = accept && col_q[0] && row_q[0];
        col_d       = !accept ? col_q : last_col ? '0 : col_q + 1'b1;
        row_d       = !(accept && last_col) ? row_q : last_row ? '0 : row_q + 1'b1;
        h_d         = (accept && !col_q[0]) ? pool.in_data : h_q;
        ocnt_d      = !fire ? ocnt_q : last_out ? '0 : ocnt_q + 1'b1;
        out_data_d  = fire ? relu(win_max) : out_data_q;
        out_valid_d = fire;
        finish_d    = fire && last_out;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            ocnt_q      <= '0;
            h_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ocnt_q      <= ocnt_d;
            h_q         <= h_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            finish_q    <= finish_d;
        end

    assign pool.out_data  = out_data_q;
    assign pool.out_valid = out_valid_q;
    assign pool.finish    = finish_q;
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb_relu_maxpool_2x2: directed and randomized frames checked against a window-max model
module tb_relu_maxpool_2x2;
    localparam int W = 8;
    localparam int H = 8;
    localparam int NO = (W / 2) * (H / 2);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    relu_maxpool_2x2_if #(.DATA_W(32)) bus ();
    relu_maxpool_2x2 #(.DATA_W(32), .IN_W(W), .IN_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .pool  (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int stray_fin = 0;
    int reset_viol = 0;
    logic [31:0] frm [W*H];
    logic [31:0] exp_q [$];
    logic [31:0] got_d [$];
    bit          got_f [$];
    int          got_c [$];

    always @(negedge clk) begin
        cyc++;
        if (bus.out_valid) begin
            got_d.push_back(bus.out_data);
            got_f.push_back(bus.finish);
            got_c.push_back(cyc);
        end
        if (bus.finish && !bus.out_valid) stray_fin++;
        if (!reset && bus.out_valid) reset_viol++;
    end

    // Reference: plain signed max over each 2x2 window, clamp negatives to zero.
    function automatic void model_push();
        for (int i = 0; i < H / 2; i++)
            for (int j = 0; j < W / 2; j++) begin
                int m;
                m = int'(frm[(2 * i) * W + 2 * j]);
                for (int di = 0; di < 2; di++)
                    for (int dj = 0; dj < 2; dj++)
                        if (int'(frm[(2 * i + di) * W + 2 * j + dj]) > m)
                            m = int'(frm[(2 * i + di) * W + 2 * j + dj]);
                exp_q.push_back(m < 0 ? 32'd0 : 32'(m));
            end
    endfunction

    task automatic idle(input int n);
        bus.in_invalid = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        bus.in_data = d;
        bus.in_invalid = 1'b0;
        @(posedge clk);
        #1;
        bus.in_invalid = 1'b1;
    endtask

    task automatic send_frame(input bit alt, input int gap_pct);
        for (int k = 0; k < W * H; k++) begin
            while ($urandom_range(99) < gap_pct) idle(1);
            send(frm[k]);
            if (alt) idle(1);
        end
    endtask

    task automatic load_ramp(input int off);
        for (int k = 0; k < W * H; k++) frm[k] = 32'(k + off);
    endtask

    task automatic clear_all();
        got_d.delete();
        got_f.delete();
        got_c.delete();
        exp_q.delete();
        stray_fin = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_invalid = 1'b1;
        bus.in_data = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++;
        if (bus.finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b want 0", bus.finish); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp();
        clear_all();
        load_ramp(0);
        send_frame(0, 0);
        idle(4);
        n_cmp++;
        if (got_d.size() !== NO) begin n_fail++; $display("FAIL ramp_count: got %0d want %0d", got_d.size(), NO); end
        for (int i = 0; i < NO && i < got_d.size(); i++) begin
            int e;
            e = (2 * (i / 4) + 1) * 8 + 2 * (i % 4) + 1;
            n_cmp++;
            if (got_d[i] !== 32'(e)) begin n_fail++; $display("FAIL ramp[%0d]: got %0d want %0d", i, got_d[i], e); end
            n_cmp++;
            if (got_f[i] !== (i == NO - 1)) begin n_fail++; $display("FAIL ramp_finish[%0d]: got %b want %b", i, got_f[i], i == NO - 1); end
        end
    endtask

    task automatic test_negative();
        clear_all();
        for (int k = 0; k < W * H; k++) frm[k] = 32'hFFFF_FFFB;
        send_frame(0, 0);
        idle(4);
        n_cmp++;
        if (got_d.size() !== NO) begin n_fail++; $display("FAIL neg_count: got %0d want %0d", got_d.size(), NO); end
        for (int i = 0; i < NO && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== 32'd0) begin n_fail++; $display("FAIL neg[%0d]: got %h want 0", i, got_d[i]); end
        end
        n_cmp++;
        if (got_d.size() == NO && got_f[NO-1] !== 1'b1) begin n_fail++; $display("FAIL neg_finish: got %b want 1", got_f[NO-1]); end
    endtask

    task automatic test_signed();
        clear_all();
        for (int k = 0; k < W * H; k++) frm[k] = '0;
        frm[0] = 32'hFFFF_FFFD;
        frm[1] = 32'd7;
        frm[W] = 32'h7FFF_FFFF;
        frm[W+1] = 32'h8000_0000;
        frm[2] = 32'h8000_0000;
        frm[3] = 32'h8000_0000;
        frm[W+2] = 32'h8000_0000;
        frm[W+3] = 32'h8000_0000;
        model_push();
        send_frame(0, 0);
        idle(4);
        n_cmp++;
        if (got_d.size() !== NO) begin n_fail++; $display("FAIL signed_count: got %0d want %0d", got_d.size(), NO); end
        n_cmp++;
        if (got_d.size() > 0 && got_d[0] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL signed_win0: got %h want 7fffffff", got_d[0]); end
        n_cmp++;
        if (got_d.size() > 1 && got_d[1] !== 32'd0) begin n_fail++; $display("FAIL signed_win1: got %h want 0", got_d[1]); end
        for (int i = 2; i < NO && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL signed[%0d]: got %h want %h", i, got_d[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        clear_all();
        load_ramp(0);
        model_push();
        send_frame(1, 0);
        idle(6);
        n_cmp++;
        if (got_d.size() !== NO) begin n_fail++; $display("FAIL gaps_count: got %0d want %0d", got_d.size(), NO); end
        for (int i = 0; i < NO && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL gaps[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_data !== 32'd63) begin n_fail++; $display("FAIL gaps_hold: got %0d want 63", bus.out_data); end
        n_cmp++;
        if (stray_fin !== 0) begin n_fail++; $display("FAIL gaps_stray_finish: got %0d want 0", stray_fin); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int nfin;
        clear_all();
        load_ramp(0);
        for (int k = 0; k < 20; k++) send(frm[k]);
        got_d.delete();
        got_f.delete();
        reset_viol = 0;
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        n_cmp++;
        if (got_d.size() !== 0) begin n_fail++; $display("FAIL rst_quiet: got %0d outputs want 0", got_d.size()); end
        model_push();
        send_frame(0, 0);
        idle(4);
        n_cmp++;
        if (got_d.size() !== NO) begin n_fail++; $display("FAIL rst_count: got %0d want %0d", got_d.size(), NO); end
        nfin = 0;
        for (int i = 0; i < NO && i < got_d.size(); i++) begin
            nfin += int'(got_f[i]);
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL rst[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
        end
        n_cmp++;
        if (nfin !== 1) begin n_fail++; $display("FAIL rst_finish_count: got %0d want 1", nfin); end
        n_cmp++;
        if (reset_viol !== 0) begin n_fail++; $display("FAIL rst_valid_in_reset: got %0d want 0", reset_viol); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        load_ramp(0);
        model_push();
        send_frame(0, 0);
        load_ramp(100);
        model_push();
        send_frame(0, 0);
        idle(4);
        n_cmp++;
        if (got_d.size() !== 2 * NO) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_d.size(), 2 * NO); end
        for (int i = 0; i < 2 * NO && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b[%0d]: got %0d want %0d", i, got_d[i], exp_q[i]); end
            n_cmp++;
            if (got_f[i] !== (i % NO == NO - 1)) begin n_fail++; $display("FAIL b2b_finish[%0d]: got %b want %b", i, got_f[i], i % NO == NO - 1); end
        end
        n_cmp++;
        if (got_d.size() == 2 * NO && got_c[2*NO-1] - got_c[NO-1] !== W * H)
            begin n_fail++; $display("FAIL b2b_finish_gap: got %0d want %0d", got_c[2*NO-1] - got_c[NO-1], W * H); end
    endtask

    task automatic test_random();
        clear_all();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < W * H; k++) begin
                case ($urandom_range(7))
                    0: frm[k] = 32'h8000_0000;
                    1: frm[k] = 32'h7FFF_FFFF;
                    2: frm[k] = 32'($urandom_range(20)) - 32'd10;
                    default: frm[k] = $urandom;
                endcase
            end
            model_push();
            send_frame(0, 30);
        end
        idle(4);
        n_cmp++;
        if (got_d.size() !== 3 * NO) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_d.size(), 3 * NO); end
        for (int i = 0; i < 3 * NO && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand[%0d]: got %h want %h", i, got_d[i], exp_q[i]); end
            n_cmp++;
            if (got_f[i] !== (i % NO == NO - 1)) begin n_fail++; $display("FAIL rand_finish[%0d]: got %b want %b", i, got_f[i], i % NO == NO - 1); end
        end
        n_cmp++;
        if (stray_fin !== 0) begin n_fail++; $display("FAIL rand_stray_finish: got %0d want 0", stray_fin); end
    endtask

    initial begin
        bus.in_invalid = 1'b1;
        bus.in_data = '0;
        test_reset();
        test_ramp();
        test_negative();
        test_signed();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
